// File: rtl/instr_mem_loader_pkg.sv
// -----------------------------------------------------------------------------
// instr_mem_loader_pkg
// Shared definitions for the boot-time instruction memory loader: the loader
// FSM state encoding and the number of stream bytes that make one memory word.
// -----------------------------------------------------------------------------
package instr_mem_loader_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LEN_HI,
        LEN_LO,
        DATA,
        WRITE,
        CHK,
        DONE,
        ERROR
    } loaderState_e;

    localparam int WORD_BYTES = 4;

endpackage

// File: rtl/instr_mem_loader_byte_packer.sv
// -----------------------------------------------------------------------------
// instr_mem_loader_byte_packer
// Packs big-endian stream bytes into 32-bit words and keeps a running XOR
// checksum over every byte it packs.
//
// Ports:
//   clkIn          in   system clock, rising edge
//   rstN           in   asynchronous active-low reset
//   clear          in   restart a new image: byte index and checksum to zero
//   byteAccept     in   byteIn is consumed as a data byte this cycle
//   byteIn         in   stream byte
//   assembledWord  out  word including this cycle's byte (valid with wordReady)
//   checksum       out  XOR of all data bytes packed since the last clear
//   wordReady      out  strobe: this accept completes a word
// -----------------------------------------------------------------------------
module instr_mem_loader_byte_packer
    import instr_mem_loader_pkg::*;
(
    input  logic        clkIn,
    input  logic        rstN,
    input  logic        clear,
    input  logic        byteAccept,
    input  logic [7:0]  byteIn,
    output logic [31:0] assembledWord,
    output logic [7:0]  checksum,
    output logic        wordReady
);

    logic [1:0]  byteIdx;
    logic [31:0] shiftReg;

    // The completed word is exposed combinationally so the top can latch it on
    // the same edge that accepts the last byte, giving a one-cycle write latency.
    assign assembledWord = {shiftReg[23:0], byteIn};
    assign wordReady     = byteAccept && (byteIdx == 2'(WORD_BYTES - 1));

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clkIn or negedge rstN) begin
        if (!rstN) begin
            byteIdx  <= 2'd0;
            shiftReg <= 32'd0;
            checksum <= 8'd0;
        end else if (clear) begin
            byteIdx  <= 2'd0;
            checksum <= 8'd0;
        end else if (byteAccept) begin
            byteIdx  <= byteIdx + 2'd1;
            shiftReg <= assembledWord;
            checksum <= checksum ^ byteIn;
        end
    end

endmodule

// File: rtl/instr_mem_loader.sv
// -----------------------------------------------------------------------------
// instr_mem_loader
// Boot-time writer for the instruction memory. Receives LEN_HI, LEN_LO, 4*N
// data bytes and an XOR checksum byte over a valid/ready handshake, writes
// each packed word sequentially from BASE_ADDR, and releases the processor
// only after a complete image with a good checksum.
//
// Ports:
//   clkIn      in   system clock, rising edge
//   rstN       in   asynchronous active-low reset
//   start      in   one-cycle pulse, begins a load from IDLE, DONE or ERROR
//   byteIn     in   stream byte
//   byteValid  in   byteIn is valid this cycle
//   byteReady  out  loader accepts byteIn this cycle
//   memWe      out  instruction memory write enable (one pulse per word)
//   memAddr    out  instruction memory byte address (held between writes)
//   memData    out  instruction memory write data (held between writes)
//   cpuHold    out  1 = processor PC held in reset
//   done       out  image loaded and checksum good
//   error      out  length or checksum failure
// -----------------------------------------------------------------------------
module instr_mem_loader
    import instr_mem_loader_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          MAX_WORDS = 256
) (
    input  logic        clkIn,
    input  logic        rstN,
    input  logic        start,
    input  logic [7:0]  byteIn,
    input  logic        byteValid,
    output logic        byteReady,
    output logic        memWe,
    output logic [31:0] memAddr,
    output logic [31:0] memData,
    output logic        cpuHold,
    output logic        done,
    output logic        error
);

    loaderState_e state, stateNext;

    logic [7:0]  lenHi;
    logic [15:0] wordCount;
    logic [15:0] wordIdx;
    logic [15:0] lenValue;
    logic        byteAccept;
    logic        lenLoAccept;
    logic        wordReady;
    logic [31:0] assembledWord;
    logic [7:0]  checksum;

    // byteReady depends on state alone so the accept path into the packer and
    // back into next-state logic has no combinational loop.
    assign byteReady   = (state == LEN_HI) || (state == LEN_LO) ||
                         (state == DATA)   || (state == CHK);
    assign byteAccept  = byteValid && byteReady;
    assign lenLoAccept = byteAccept && (state == LEN_LO);
    assign lenValue    = {lenHi, byteIn};

    // Clearing on every header, including N == 0, keeps a stale checksum from
    // a previous image out of the CHK comparison.
    instr_mem_loader_byte_packer u_packer (
        .clkIn         (clkIn),
        .rstN          (rstN),
        .clear         (lenLoAccept),
        .byteAccept    (byteAccept && (state == DATA)),
        .byteIn        (byteIn),
        .assembledWord (assembledWord),
        .checksum      (checksum),
        .wordReady     (wordReady)
    );

    always_ff @(posedge clkIn or negedge rstN) begin
        if (!rstN) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    // NOTE: every output of this block gets a default first, so no path
    // through the case statement can leave a value unassigned and infer a latch.
    always_comb begin
        stateNext = state;
        memWe     = 1'b0;
        cpuHold   = 1'b1;
        done      = 1'b0;
        error     = 1'b0;
        case (state)
            IDLE: begin
                if (start) stateNext = LEN_HI;
            end
            LEN_HI: begin
                if (byteValid) stateNext = LEN_LO;
            end
            LEN_LO: begin
                if (byteValid) begin
                    if (32'(lenValue) > 32'(MAX_WORDS)) stateNext = ERROR;
                    else if (lenValue == 16'd0)         stateNext = CHK;
                    else                                stateNext = DATA;
                end
            end
            DATA: begin
                if (wordReady) stateNext = WRITE;
            end
            WRITE: begin
                memWe     = 1'b1;
                stateNext = (wordIdx + 16'd1 == wordCount) ? CHK : DATA;
            end
            CHK: begin
                if (byteValid) stateNext = (byteIn == checksum) ? DONE : ERROR;
            end
            DONE: begin
                cpuHold = 1'b0;
                done    = 1'b1;
                if (start) stateNext = LEN_HI;
            end
            ERROR: begin
                error = 1'b1;
                if (start) stateNext = LEN_HI;
            end
            default: stateNext = IDLE;
        endcase
    end

    // NOTE: the instruction memory itself lives outside this block and is not
    // reset; only the write-port registers here get reset values.
    always_ff @(posedge clkIn or negedge rstN) begin
        if (!rstN) begin
            lenHi     <= 8'd0;
            wordCount <= 16'd0;
            wordIdx   <= 16'd0;
            memAddr   <= BASE_ADDR;
            memData   <= 32'd0;
        end else begin
            if (byteAccept && (state == LEN_HI)) lenHi <= byteIn;
            if (lenLoAccept) begin
                wordCount <= lenValue;
                wordIdx   <= 16'd0;
            end
            // Address and data are latched once per word so they hold steady
            // while the next word is being received.
            if (wordReady) begin
                memData <= assembledWord;
                memAddr <= BASE_ADDR + {14'd0, wordIdx, 2'b00};
            end
            if (state == WRITE) wordIdx <= wordIdx + 16'd1;
        end
    end

endmodule
